mem_port_arbiter: RTL and testbench

Two-master arbiter that shares the data-side ports of the single-cycle core's ideal memory: the one write port and read port 2. Requester 0 is the CPU load/store path; requester 1 is the debug/loader engine. The block arbitrates round-robin and supports locked bursts with a fairness cap. Because the memory reads asynchronously, the block registers read data and returns it with a one-cycle `rvalid` pulse.

---
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-master round-robin arbiter for the data-side memory write port and read port 2.
// Supports locked bursts capped at MAX_BURST while the other master waits; read data is registered.
module mem_port_arbiter #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned MAX_BURST  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  m0_req,
   input  logic                  m0_wr,
   input  logic                  m0_lock,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [31:0]           m0_wdata,
   input  logic                  m1_req,
   input  logic                  m1_wr,
   input  logic                  m1_lock,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [31:0]           m1_wdata,
   output logic                  m0_gnt,
   output logic                  m1_gnt,
   output logic                  m0_rvalid,
   output logic                  m1_rvalid,
   output logic [31:0]           m0_rdata,
   output logic [31:0]           m1_rdata,
   output logic [ADDR_WIDTH-1:0] mem_Waddr,
   output logic [ADDR_WIDTH-1:0] mem_Raddr,
   output logic                  mem_Wren,
   output logic                  mem_Rden,
   output logic [31:0]           mem_Wdata,
   input  logic [31:0]           mem_Rdata
);

   localparam int unsigned CW  = 4;
   localparam int unsigned CW1 = CW + 1;
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD0 = 2'd1,
      HOLD1 = 2'd2
   } state_t;

   state_t                r_state, w_next_state;
   logic                  r_last, w_next_last;
   logic [CW-1:0]         r_cnt, w_next_cnt;
   logic [CW1-1:0]        w_cnt_inc;
   logic [CW-1:0]         w_new_cnt;
   logic                  w_gnt0, w_gnt1, w_gnt_any;
   logic                  w_sel_wr, w_sel_lock, w_other_req;
   logic [ADDR_WIDTH-1:0] w_sel_addr;
   logic [31:0]           w_sel_wdata;
   logic                  r_m0_rvalid, r_m1_rvalid;
   logic [31:0]           r_m0_rdata, r_m1_rdata;

   // State register: FSM state, most recent grantee and burst count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_last  <= 1'b1;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next_state;
         r_last  <= w_next_last;
         r_cnt   <= w_next_cnt;
      end
   end

   // Next-state logic; a forced release returns to IDLE where r_last favours the waiter
   always_comb begin
      w_next_state = r_state;
      w_next_last  = r_last;
      w_next_cnt   = r_cnt;
      w_cnt_inc    = CW1'(r_cnt) + CW1'(1);
      w_new_cnt    = (w_cnt_inc >= CW1'(MAX_BURST)) ? MAX_CNT : w_cnt_inc[CW-1:0];
      if (w_gnt_any) begin
         w_next_last = w_gnt1;
      end
      case (r_state)
         HOLD0, HOLD1: begin
            if (!w_gnt_any || !w_sel_lock || ((w_new_cnt >= MAX_CNT) && w_other_req)) begin
               w_next_state = IDLE;
               w_next_cnt   = '0;
            end else begin
               w_next_cnt = w_new_cnt;
            end
         end
         default: begin
            if (w_gnt_any && w_sel_lock && !((MAX_BURST == 32'd1) && w_other_req)) begin
               w_next_state = w_gnt1 ? HOLD1 : HOLD0;
               w_next_cnt   = CW'(1);
            end
         end
      endcase
   end

   // Output logic: grants and memory drive from the granted master, all zero in reset
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (!rst) begin
         case (r_state)
            HOLD0:   w_gnt0 = m0_req;
            HOLD1:   w_gnt1 = m1_req;
            default: begin
               if (m0_req && m1_req) begin
                  w_gnt0 = r_last;
                  w_gnt1 = !r_last;
               end else begin
                  w_gnt0 = m0_req;
                  w_gnt1 = m1_req;
               end
            end
         endcase
      end
      w_gnt_any   = w_gnt0 | w_gnt1;
      w_sel_wr    = w_gnt1 ? m1_wr    : m0_wr;
      w_sel_lock  = w_gnt1 ? m1_lock  : m0_lock;
      w_sel_addr  = w_gnt1 ? m1_addr  : m0_addr;
      w_sel_wdata = w_gnt1 ? m1_wdata : m0_wdata;
      w_other_req = w_gnt1 ? m0_req   : m1_req;
      mem_Wren    = w_gnt_any & w_sel_wr;
      mem_Rden    = w_gnt_any & ~w_sel_wr;
      mem_Waddr   = mem_Wren ? w_sel_addr  : '0;
      mem_Wdata   = mem_Wren ? w_sel_wdata : '0;
      mem_Raddr   = mem_Rden ? w_sel_addr  : '0;
   end

   // Read return: capture asynchronous memory data at the granting edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_m0_rvalid <= 1'b0;
         r_m1_rvalid <= 1'b0;
         r_m0_rdata  <= '0;
         r_m1_rdata  <= '0;
      end else begin
         r_m0_rvalid <= w_gnt0 & ~m0_wr;
         r_m1_rvalid <= w_gnt1 & ~m1_wr;
         if (w_gnt0 && !m0_wr) begin
            r_m0_rdata <= mem_Rdata;
         end
         if (w_gnt1 && !m1_wr) begin
            r_m1_rdata <= mem_Rdata;
         end
      end
   end

   assign m0_gnt    = w_gnt0;
   assign m1_gnt    = w_gnt1;
   assign m0_rvalid = r_m0_rvalid;
   assign m1_rvalid = r_m1_rvalid;
   assign m0_rdata  = r_m0_rdata;
   assign m1_rdata  = r_m1_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of per-cycle requests with expected grants,
// a reference memory and a read-return scoreboard, plus a reset-during-burst sequence.
module tb_mem_port_arbiter;

   localparam int unsigned AW = 10;
   localparam int unsigned MB = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          m0_req, m0_wr, m0_lock, m1_req, m1_wr, m1_lock;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [31:0]   m0_wdata, m1_wdata;
   logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic [31:0]   m0_rdata, m1_rdata;
   logic [AW-1:0] mem_Waddr, mem_Raddr;
   logic          mem_Wren, mem_Rden;
   logic [31:0]   mem_Wdata, mem_Rdata;

   mem_port_arbiter #(.ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_wr(m0_wr), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m1_req(m1_req), .m1_wr(m1_wr), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
      .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
      .mem_Waddr(mem_Waddr), .mem_Raddr(mem_Raddr), .mem_Wren(mem_Wren), .mem_Rden(mem_Rden),
      .mem_Wdata(mem_Wdata), .mem_Rdata(mem_Rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_val(input logic [AW-1:0] a);
      if (a == AW'(1)) return 32'h0000_0011;
      if (a == AW'(2)) return 32'h0000_0022;
      return 32'hC0DE_0000 | 32'(a);
   endfunction

   // Environment memory: asynchronous read, write at the clock edge
   logic [31:0] mem     [0:(1<<AW)-1];
   bit          written [0:(1<<AW)-1];
   assign mem_Rdata = written[mem_Raddr] ? mem[mem_Raddr] : init_val(mem_Raddr);
   always @(posedge clk) begin
      if (mem_Wren) begin
         mem[mem_Waddr]     <= mem_Wdata;
         written[mem_Waddr] <= 1'b1;
      end
   end

   typedef struct {
      logic r0, w0, l0; logic [AW-1:0] a0; logic [31:0] d0;
      logic r1, w1, l1; logic [AW-1:0] a1; logic [31:0] d1;
      logic e0, e1;
   } vec_t;

   typedef struct {
      logic        m;
      logic [31:0] d;
   } rd_t;

   vec_t        vecs[$];
   rd_t         sbq[$];
   logic [31:0] ref_mem [0:(1<<AW)-1];
   logic [31:0] exp_rd0, exp_rd1;
   int          checks = 0;
   int          errors = 0;

   function automatic vec_t mk(input logic r0, w0, l0, input int a0, input logic [31:0] d0,
                               input logic r1, w1, l1, input int a1, input logic [31:0] d1,
                               input logic e0, e1);
      vec_t v;
      v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = AW'(a0); v.d0 = d0;
      v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = AW'(a1); v.d1 = d1;
      v.e0 = e0; v.e1 = e1;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      m0_req = v.r0; m0_wr = v.w0; m0_lock = v.l0; m0_addr = v.a0; m0_wdata = v.d0;
      m1_req = v.r1; m1_wr = v.w1; m1_lock = v.l1; m1_addr = v.a1; m1_wdata = v.d1;
   endtask

   // Post-edge check: pop expected read returns and verify rdata hold values
   task automatic check_return(input string tag);
      rd_t e;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk({tag, " rvalid0"}, 32'(m0_rvalid), 32'(!e.m));
         chk({tag, " rvalid1"}, 32'(m1_rvalid), 32'(e.m));
         if (e.m) exp_rd1 = e.d; else exp_rd0 = e.d;
      end else begin
         chk({tag, " rvalid0 idle"}, 32'(m0_rvalid), 32'd0);
         chk({tag, " rvalid1 idle"}, 32'(m1_rvalid), 32'd0);
      end
      chk({tag, " rdata0"}, m0_rdata, exp_rd0);
      chk({tag, " rdata1"}, m1_rdata, exp_rd1);
   endtask

   // One cycle: drive at edge+1, check grant/memory drive mid-cycle, check returns after edge
   task automatic step(input vec_t v, input string tag);
      logic          g, wr;
      logic [AW-1:0] a;
      logic [31:0]   d;
      drive(v);
      #3;
      chk({tag, " gnt0"}, 32'(m0_gnt), 32'(v.e0));
      chk({tag, " gnt1"}, 32'(m1_gnt), 32'(v.e1));
      if (v.e0 || v.e1) begin
         g  = v.e1;
         wr = g ? v.w1 : v.w0;
         a  = g ? v.a1 : v.a0;
         d  = g ? v.d1 : v.d0;
         if (wr) begin
            chk({tag, " Wren"}, 32'(mem_Wren), 32'd1);
            chk({tag, " Rden"}, 32'(mem_Rden), 32'd0);
            chk({tag, " Waddr"}, 32'(mem_Waddr), 32'(a));
            chk({tag, " Wdata"}, mem_Wdata, d);
            ref_mem[a] = d;
         end else begin
            chk({tag, " Rden"}, 32'(mem_Rden), 32'd1);
            chk({tag, " Wren"}, 32'(mem_Wren), 32'd0);
            chk({tag, " Raddr"}, 32'(mem_Raddr), 32'(a));
            sbq.push_back('{m: g, d: ref_mem[a]});
         end
      end else begin
         chk({tag, " Wren idle"}, 32'(mem_Wren), 32'd0);
         chk({tag, " Rden idle"}, 32'(mem_Rden), 32'd0);
      end
      @(posedge clk);
      #1;
      check_return(tag);
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_val(AW'(i));
      exp_rd0 = '0;
      exp_rd1 = '0;

      // Reset with both masters requesting writes
      rst = 1'b1;
      drive(mk(1,1,0,8,32'hA0A0A0A0, 1,1,0,9,32'hB0B0B0B0, 0,0));
      #2;
      chk("rst gnt0", 32'(m0_gnt), 32'd0);
      chk("rst gnt1", 32'(m1_gnt), 32'd0);
      chk("rst Wren", 32'(mem_Wren), 32'd0);
      chk("rst Waddr", 32'(mem_Waddr), 32'd0);
      chk("rst Wdata", mem_Wdata, 32'd0);
      chk("rst rvalid0", 32'(m0_rvalid), 32'd0);
      chk("rst rvalid1", 32'(m1_rvalid), 32'd0);
      chk("rst rdata0", m0_rdata, 32'd0);
      chk("rst rdata1", m1_rdata, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst no write", mem_Rdata === mem_Rdata ? (written[8] ? mem[8] : init_val(AW'(8))) : 32'd0, ref_mem[8]);
      rst = 1'b0;

      // Per-cycle table: inputs and expected grants
      vecs.push_back(mk(1,1,0,8,32'hA0A0A0A0, 1,1,0,9,32'hB0B0B0B0, 1,0));
      vecs.push_back(mk(0,0,0,0,0,            1,1,0,9,32'hB0B0B0B0, 0,1));
      for (int i = 0; i < 2; i++) begin
         vecs.push_back(mk(1,0,0,1,0, 1,0,0,2,0, 1,0));
         vecs.push_back(mk(1,0,0,1,0, 1,0,0,2,0, 0,1));
      end
      vecs.push_back(mk(1,1,0,5,32'hDEADBEEF, 0,0,0,0,0, 1,0));
      vecs.push_back(mk(0,0,0,0,0,            1,0,0,5,0, 0,1));
      for (int i = 0; i < 4; i++) vecs.push_back(mk(1,0,1,1,0, 1,0,0,2,0, 1,0));
      vecs.push_back(mk(1,0,1,1,0, 1,0,0,2,0, 0,1));
      vecs.push_back(mk(1,0,1,1,0, 1,0,0,2,0, 1,0));
      vecs.push_back(mk(1,0,0,1,0, 1,0,0,2,0, 1,0));
      vecs.push_back(mk(0,0,0,0,0, 1,0,0,2,0, 0,1));
      vecs.push_back(mk(1,1,1,16,32'h100, 1,0,0,16,0, 1,0));
      vecs.push_back(mk(1,1,1,17,32'h101, 1,0,0,16,0, 1,0));
      vecs.push_back(mk(1,1,0,18,32'h102, 1,0,0,16,0, 1,0));
      vecs.push_back(mk(1,0,0,17,0,       1,0,0,16,0, 0,1));
      vecs.push_back(mk(0,0,0,0,0,        0,0,0,0,0,  0,0));
      vecs.push_back(mk(1,0,1,18,0,       1,0,0,2,0,  1,0));
      vecs.push_back(mk(0,0,0,0,0,        1,0,0,2,0,  0,0));
      vecs.push_back(mk(1,0,0,17,0,       1,0,0,2,0,  0,1));
      vecs.push_back(mk(1,0,0,17,0,       0,0,0,0,0,  1,0));
      vecs.push_back(mk(0,0,0,0,0, 1,1,1,20,32'h200, 0,1));
      vecs.push_back(mk(1,0,0,1,0, 1,1,1,21,32'h201, 0,1));
      vecs.push_back(mk(1,0,0,1,0, 1,1,1,22,32'h202, 0,1));
      vecs.push_back(mk(1,0,0,1,0, 1,1,1,23,32'h203, 0,1));
      vecs.push_back(mk(1,0,0,1,0, 1,0,1,20,0,       1,0));
      vecs.push_back(mk(0,0,0,0,0, 1,0,0,23,0,       0,1));

      foreach (vecs[i]) step(vecs[i], $sformatf("v%0d", i));

      // Reset during a locked burst with a read return in flight
      drive(mk(1,0,1,2,0, 0,0,0,0,0, 0,0));
      #3;
      chk("burst gnt0", 32'(m0_gnt), 32'd1);
      @(posedge clk);
      #1;
      chk("burst rvalid0", 32'(m0_rvalid), 32'd1);
      chk("burst rdata0", m0_rdata, ref_mem[2]);
      drive(mk(1,0,1,2,0, 1,1,1,9,32'h5555_5555, 0,0));
      rst = 1'b1;
      #1;
      chk("mid rst rvalid0", 32'(m0_rvalid), 32'd0);
      chk("mid rst rdata0", m0_rdata, 32'd0);
      chk("mid rst gnt0", 32'(m0_gnt), 32'd0);
      chk("mid rst gnt1", 32'(m1_gnt), 32'd0);
      chk("mid rst Wren", 32'(mem_Wren), 32'd0);
      chk("mid rst Rden", 32'(mem_Rden), 32'd0);
      @(posedge clk);
      #1;
      chk("mid rst no write", written[9] ? mem[9] : init_val(AW'(9)), ref_mem[9]);
      rst = 1'b0;
      exp_rd0 = '0;
      exp_rd1 = '0;
      sbq.delete();
      step(mk(0,0,0,0,0, 1,1,0,9,32'h5555_5555, 0,1), "post rst write");
      step(mk(0,0,0,0,0, 1,0,0,9,0,             0,1), "post rst read");
      step(mk(0,0,0,0,0, 0,0,0,0,0,             0,0), "drain");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
